// File: rtl/id_ex_pipeline_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg_pkg
// Description : Shared constants for the ID/EX pipeline register: control-bit
//               positions inside the 8-bit control bundle, the bubble control
//               word and the flush-tracker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pipeline_reg_pkg;

    // Control bundle layout: {reg_write,mem_read,mem_write,mem_to_reg,
    //                         alu_src,branch,jump,is_muldiv}
    localparam int CTRL_W         = 8;
    localparam int CTRL_REG_WRITE = 7;
    localparam int CTRL_MEM_READ  = 6;
    localparam int CTRL_MEM_WRITE = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_SRC   = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_JUMP      = 1;
    localparam int CTRL_IS_MULDIV = 0;

    // A bubble never writes the register file or memory.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

    // Tracks a flush that arrived while EX was holding.
    typedef enum logic [0:0] {
        FLUSH_IDLE    = 1'b0,
        FLUSH_PENDING = 1'b1
    } flush_state_e;

endpackage : id_ex_pipeline_reg_pkg
`default_nettype wire

// File: rtl/id_ex_pipeline_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_reg
// Description : ID/EX pipeline register. Loads decoded ID fields each cycle,
//               inserts a bubble on flush or load-use stall, freezes while EX
//               is busy and remembers a flush that arrived during the freeze.
//               Keeps a saturating count of inserted bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic [2:0]         id_funct3,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic               hazard_stall,
    input  logic               ex_flush,
    input  logic               ex_hold,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [2:0]         ex_funct3,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [CNT_W-1:0]   bubble_cnt
);

    flush_state_e        r_flush_state;
    flush_state_e        w_flush_next;
    logic                w_load_bubble;
    logic                w_cnt_sat;

    logic                r_valid;
    logic [XLEN-1:0]     r_pc;
    logic [XLEN-1:0]     r_rs1_data;
    logic [XLEN-1:0]     r_rs2_data;
    logic [XLEN-1:0]     r_imm;
    logic [4:0]          r_rs1;
    logic [4:0]          r_rs2;
    logic [4:0]          r_rd;
    logic [2:0]          r_funct3;
    logic [ALUOP_W-1:0]  r_alu_op;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [CNT_W-1:0]    r_bubble_cnt;

    // A bubble is loaded on any non-hold cycle with a live or remembered flush,
    // or a load-use stall; flush and stall together still make one bubble.
    assign w_load_bubble = !ex_hold &&
                           (ex_flush || hazard_stall || (r_flush_state == FLUSH_PENDING));
    assign w_cnt_sat     = &r_bubble_cnt;

    // Flush tracker state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_state <= FLUSH_IDLE;
        end else begin
            r_flush_state <= w_flush_next;
        end
    end

    // Flush tracker next state: arm on a flush during hold, clear on any
    // non-hold cycle (that cycle always loads a bubble).
    always_comb begin
        w_flush_next = r_flush_state;
        if (ex_hold) begin
            if (ex_flush) begin
                w_flush_next = FLUSH_PENDING;
            end
        end else begin
            w_flush_next = FLUSH_IDLE;
        end
    end

    // Pipeline register: hold, bubble or load the ID fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_alu_op   <= '0;
            r_ctrl     <= CTRL_BUBBLE;
        end else if (!ex_hold) begin
            if (w_load_bubble) begin
                r_valid    <= 1'b0;
                r_pc       <= '0;
                r_rs1_data <= '0;
                r_rs2_data <= '0;
                r_imm      <= '0;
                r_rs1      <= '0;
                r_rs2      <= '0;
                r_rd       <= '0;
                r_funct3   <= '0;
                r_alu_op   <= '0;
                r_ctrl     <= CTRL_BUBBLE;
            end else begin
                r_valid    <= id_valid;
                r_pc       <= id_pc;
                r_rs1_data <= id_rs1_data;
                r_rs2_data <= id_rs2_data;
                r_imm      <= id_imm;
                r_rs1      <= id_rs1;
                r_rs2      <= id_rs2;
                r_rd       <= id_rd;
                r_funct3   <= id_funct3;
                r_alu_op   <= id_alu_op;
                r_ctrl     <= id_valid ? id_ctrl : CTRL_BUBBLE;
            end
        end
    end

    // Saturating bubble counter: counts only bubbles loaded by flush/stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
        end else if (w_load_bubble && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_funct3   = r_funct3;
    assign ex_alu_op   = r_alu_op;
    assign ex_ctrl     = r_ctrl;
    assign bubble_cnt  = r_bubble_cnt;

endmodule : id_ex_pipeline_reg
`default_nettype wire
